btn_conditioner: RTL and testbench

//   Conditions raw Basys3 push-buttons into clean control strobes for the Moore sequence FSM.

---
 rtl/btn_pkg.sv | 13 +
 rtl/btn_debounce_ch.sv | 81 ++++++++
 rtl/btn_conditioner.sv | 28 ++
 tb/tb_btn_conditioner.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioning path.
package btn_pkg;

  typedef enum logic [1:0] {IDLE, ARM_P, HELD, ARM_R} db_state_t;

  localparam int DB_CYCLES_DEFAULT = 1_000_000;

  // Debounce counter width; a single bit is kept even for DB_CYCLES of 1 or 2.
  function automatic int cnt_width(input int cycles);
    return ($clog2(cycles) > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, debounce FSM with hold counter,
// registered level and single-cycle press strobe.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic R,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int CNT_W = cnt_width(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  db_state_t        state_reg;
  db_state_t        state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             level_reg;
  logic             level_next;
  logic             pulse_reg;
  logic             pulse_next;
  logic             cnt_done;

  assign cnt_done = (cnt_reg == CNT_MAX);

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      state_reg <= IDLE;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      pulse_reg <= pulse_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sync2_reg) state_next = ARM_P;
      ARM_P:   if (!sync2_reg) state_next = IDLE;
               else if (cnt_done) state_next = HELD;
      HELD:    if (!sync2_reg) state_next = ARM_R;
      ARM_R:   if (sync2_reg) state_next = HELD;
               else if (cnt_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counter restarts on every entry into an ARM state and saturates at CNT_MAX.
  always_comb begin
    cnt_next   = cnt_reg;
    pulse_next = 1'b0;
    case (state_reg)
      IDLE:    if (sync2_reg) cnt_next = '0;
      ARM_P:   if (sync2_reg && !cnt_done) cnt_next = cnt_reg + CNT_W'(1);
      HELD:    if (!sync2_reg) cnt_next = '0;
      ARM_R:   if (!sync2_reg && !cnt_done) cnt_next = cnt_reg + CNT_W'(1);
      default: cnt_next = '0;
    endcase
    if (state_reg == ARM_P && sync2_reg && cnt_done) pulse_next = 1'b1;
    level_next = (state_next == HELD) || (state_next == ARM_R);
  end

  assign btn_level = level_reg;
  assign btn_pulse = pulse_reg;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions raw push-buttons into debounced levels and one-clock press strobes;
// each channel is an independent btn_debounce_ch.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN     = 2,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             R,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse
);

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    btn_debounce_ch #(
      .DB_CYCLES(DB_CYCLES)
    ) u_ch (
      .clk      (clk),
      .R        (R),
      .btn_raw  (btn_raw[gi]),
      .btn_level(btn_level[gi]),
      .btn_pulse(btn_pulse[gi])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed checks of btn_conditioner with DB_CYCLES=4 and two channels.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       R = 1'b1;
  logic [1:0] btn_raw = 2'b00;
  logic [1:0] btn_level;
  logic [1:0] btn_pulse;

  int checks = 0;
  int errors = 0;

  btn_conditioner #(
    .N_BTN    (2),
    .DB_CYCLES(4)
  ) dut (
    .clk      (clk),
    .R        (R),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse)
  );

  always #5 clk = ~clk;

  // Advance one active edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    btn_raw = 2'b00;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    #3;
    checks++;
    if ({btn_level, btn_pulse} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async got %b exp 0000", {btn_level, btn_pulse});
    end
    btn_raw = 2'b11;
    repeat (3) tick();
    checks++;
    if ({btn_level, btn_pulse} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_held got %b exp 0000", {btn_level, btn_pulse});
    end
    btn_raw = 2'b00;
    R = 1'b0;
    exp = 4'b0000;
    repeat (5) tick();
    checks++;
    if ({btn_level, btn_pulse} !== exp) begin
      errors++;
      $display("FAIL reset_release got %b exp %b", {btn_level, btn_pulse}, exp);
    end
    $display("test_reset done");
  endtask

  // Press sampled at edge i=1 qualifies at edge 1+DB_CYCLES+2 = 7.
  task automatic test_clean_press();
    logic [1:0] exp_p, exp_l;
    btn_raw = 2'b01;
    for (int i = 1; i <= 50; i++) begin
      tick();
      exp_p = {1'b0, i == 7};
      exp_l = {1'b0, i >= 7};
      checks++;
      if (btn_pulse !== exp_p || btn_level !== exp_l) begin
        errors++;
        $display("FAIL clean_press cyc %0d pulse %b exp %b level %b exp %b",
                 i, btn_pulse, exp_p, btn_level, exp_l);
      end
    end
    btn_raw = 2'b00;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_l = {1'b0, i < 7};
      checks++;
      if (btn_pulse !== 2'b00 || btn_level !== exp_l) begin
        errors++;
        $display("FAIL clean_release cyc %0d pulse %b exp 00 level %b exp %b",
                 i, btn_pulse, btn_level, exp_l);
      end
    end
    $display("test_clean_press done");
  endtask

  task automatic test_bounce();
    logic [1:0] exp_p, exp_l;
    for (int i = 1; i <= 20; i++) begin
      btn_raw = {1'b0, ((i - 1) / 2) % 2 == 0};
      tick();
      checks++;
      if (btn_pulse !== 2'b00 || btn_level !== 2'b00) begin
        errors++;
        $display("FAIL bounce_toggle cyc %0d pulse %b level %b exp 00 00",
                 i, btn_pulse, btn_level);
      end
    end
    btn_raw = 2'b01;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_p = {1'b0, i == 7};
      exp_l = {1'b0, i >= 7};
      checks++;
      if (btn_pulse !== exp_p || btn_level !== exp_l) begin
        errors++;
        $display("FAIL bounce_settle cyc %0d pulse %b exp %b level %b exp %b",
                 i, btn_pulse, exp_p, btn_level, exp_l);
      end
    end
    $display("test_bounce done");
  endtask

  // Entered with channel 0 HELD; 1-cycle highs at cycles 3 and 7 restart the release count.
  task automatic test_release_glitch();
    logic [1:0] exp_l;
    for (int i = 1; i <= 20; i++) begin
      btn_raw = {1'b0, (i == 3) || (i == 7)};
      tick();
      exp_l = {1'b0, i < 14};
      checks++;
      if (btn_pulse !== 2'b00 || btn_level !== exp_l) begin
        errors++;
        $display("FAIL release_glitch cyc %0d pulse %b exp 00 level %b exp %b",
                 i, btn_pulse, btn_level, exp_l);
      end
    end
    $display("test_release_glitch done");
  endtask

  task automatic test_two_channels();
    logic [1:0] exp_p;
    btn_raw = 2'b11;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_p = (i == 7) ? 2'b11 : 2'b00;
      checks++;
      if (btn_pulse !== exp_p) begin
        errors++;
        $display("FAIL two_ch_press cyc %0d pulse %b exp %b", i, btn_pulse, exp_p);
      end
    end
    checks++;
    if (btn_level !== 2'b11) begin
      errors++;
      $display("FAIL two_ch_level got %b exp 11", btn_level);
    end
    settle();
    for (int i = 1; i <= 15; i++) begin
      btn_raw = {i <= 3, 1'b0};
      tick();
      checks++;
      if (btn_pulse !== 2'b00 || btn_level !== 2'b00) begin
        errors++;
        $display("FAIL short_ch1 cyc %0d pulse %b level %b exp 00 00",
                 i, btn_pulse, btn_level);
      end
    end
    $display("test_two_channels done");
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp_p;
    btn_raw = 2'b01;
    repeat (4) tick();
    #2 R = 1'b1;
    #1;
    checks++;
    if ({btn_level, btn_pulse} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_arm_p got %b exp 0000", {btn_level, btn_pulse});
    end
    repeat (2) tick();
    R = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_p = {1'b0, i == 7};
      checks++;
      if (btn_pulse !== exp_p) begin
        errors++;
        $display("FAIL rearm_after_arm_p cyc %0d pulse %b exp %b", i, btn_pulse, exp_p);
      end
    end
    checks++;
    if (btn_level !== 2'b01) begin
      errors++;
      $display("FAIL held_before_reset level %b exp 01", btn_level);
    end
    #2 R = 1'b1;
    #1;
    checks++;
    if ({btn_level, btn_pulse} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_held_state got %b exp 0000", {btn_level, btn_pulse});
    end
    repeat (2) tick();
    R = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_p = {1'b0, i == 7};
      checks++;
      if (btn_pulse !== exp_p) begin
        errors++;
        $display("FAIL rearm_after_held cyc %0d pulse %b exp %b", i, btn_pulse, exp_p);
      end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_long_hold();
    int   pulses = 0;
    logic prev = 1'b0;
    logic both;
    btn_raw = 2'b01;
    for (int i = 1; i <= 1000; i++) begin
      tick();
      both = prev & btn_pulse[0];
      checks++;
      if (both !== 1'b0) begin
        errors++;
        $display("FAIL pulse_consecutive cyc %0d pulse high twice in a row", i);
      end
      if (btn_pulse[0]) pulses++;
      prev = btn_pulse[0];
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL long_hold_pulses got %0d exp 1", pulses);
    end
    checks++;
    if (btn_level !== 2'b01) begin
      errors++;
      $display("FAIL long_hold_level got %b exp 01", btn_level);
    end
    $display("test_long_hold done, pulses=%0d", pulses);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    settle();
    test_bounce();
    test_release_glitch();
    settle();
    test_two_channels();
    settle();
    test_reset_mid();
    settle();
    test_long_hold();
    settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
